// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared constants and helpers for the memory-access stage.
//   CPU_WIDTH / REG_ADDR_WIDTH  datapath and register-index widths
//   INST_TYPE_IL / INST_TYPE_S  load and store opcodes
//   mem_size_e                  access size decoded from funct3[1:0]
// Optional feature macro consumed by mem_lsu: MEM_MISALIGN_TRAP_EN
package mem_lsu_pkg;

  localparam int unsigned CPU_WIDTH      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  localparam logic [6:0] INST_TYPE_IL = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S  = 7'b0100011;

  // funct3[1:0] size codes; funct3[2] selects zero-extension on loads
  localparam logic [1:0] F3_SZ_BYTE = 2'b00;
  localparam logic [1:0] F3_SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  function automatic mem_size_e f3_to_size(input logic [2:0] f3);
    mem_size_e sz;
    case (f3[1:0])
      F3_SZ_BYTE: sz = SZ_BYTE;
      F3_SZ_HALF: sz = SZ_HALF;
      default:    sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational lane logic for the load/store unit.
//   Store side: i_st_size/i_st_off/i_st_data -> o_be (byte enables),
//               o_wdata (lane-replicated store data)
//   Load side:  i_ld_size/i_ld_off/i_ld_unsigned/i_rdata -> o_ld_data
//               (selected lane, sign- or zero-extended to 32 bits)
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]           i_st_size,
  input  logic [1:0]           i_st_off,
  input  logic [CPU_WIDTH-1:0] i_st_data,
  output logic [3:0]           o_be,
  output logic [CPU_WIDTH-1:0] o_wdata,
  input  logic [1:0]           i_ld_size,
  input  logic [1:0]           i_ld_off,
  input  logic                 i_ld_unsigned,
  input  logic [CPU_WIDTH-1:0] i_rdata,
  output logic [CPU_WIDTH-1:0] o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    case (i_st_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_be    = '1;
        o_wdata = i_st_data;
      end
    endcase
  end

  assign w_ld_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
  assign w_ld_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_ld_data = '0;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = i_ld_unsigned ? {24'h0, w_ld_byte}
                                         : {{24{w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: o_ld_data = i_ld_unsigned ? {16'h0, w_ld_half}
                                         : {{16{w_ld_half[15]}}, w_ld_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit of the memory-access stage.
// Decodes the instruction held in the EX/MEM register, runs a req/gnt/rvalid
// data-bus transaction for loads and stores, stalls the pipeline until the
// access completes and registers the extended load result.
//   clk, rst (async, active-high)
//   inst_i, alu_res_i, rs2_data_i, reg_wr_en_i  from the EX/MEM register
//   adv_i         flow controller advances the upstream register
//   dbus_*        registered data-bus request, gnt/rvalid/rdata responses
//   mem_stall_o   combinational stall request
//   load_data_o   registered extended load data
//   reg_wr_en_o   write enable, suppressed on a misaligned access
//   misalign_o    misaligned-access flag
// Macro MEM_MISALIGN_TRAP_EN: when defined, misaligned half/word accesses are
// flagged and never reach the bus; otherwise the address is truncated to
// natural alignment and misalign_o is tied low.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] inst_i,
  input  logic [CPU_WIDTH-1:0] alu_res_i,
  input  logic [CPU_WIDTH-1:0] rs2_data_i,
  input  logic                 reg_wr_en_i,
  input  logic                 adv_i,
  output logic                 dbus_req_o,
  output logic                 dbus_we_o,
  output logic [CPU_WIDTH-1:0] dbus_addr_o,
  output logic [3:0]           dbus_be_o,
  output logic [CPU_WIDTH-1:0] dbus_wdata_o,
  input  logic                 dbus_gnt_i,
  input  logic                 dbus_rvalid_i,
  input  logic [CPU_WIDTH-1:0] dbus_rdata_i,
  output logic                 mem_stall_o,
  output logic [CPU_WIDTH-1:0] load_data_o,
  output logic                 reg_wr_en_o,
  output logic                 misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [6:0]           w_opcode;
  logic [2:0]           w_f3;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_access;
  logic                 w_access_ok;
  logic                 w_misalign;
  logic                 w_stall;
  mem_size_e            w_size;
  logic [CPU_WIDTH-1:0] w_eff_addr;
  logic [3:0]           w_be;
  logic [CPU_WIDTH-1:0] w_wdata;
  logic [CPU_WIDTH-1:0] w_ld_ext;
  logic                 w_unused_inst;

  logic                 r_req;
  logic                 r_we;
  logic [CPU_WIDTH-1:0] r_addr;
  logic [3:0]           r_be;
  logic [CPU_WIDTH-1:0] r_wdata;
  logic [1:0]           r_ld_size;
  logic [1:0]           r_ld_off;
  logic                 r_ld_uns;
  logic [CPU_WIDTH-1:0] r_load_data;

  assign w_opcode   = inst_i[6:0];
  assign w_f3       = inst_i[14:12];
  assign w_is_load  = (w_opcode == INST_TYPE_IL);
  assign w_is_store = (w_opcode == INST_TYPE_S);
  assign w_access   = w_is_load | w_is_store;
  assign w_size     = f3_to_size(w_f3);

  // rd and the upper immediate/register fields are not needed here
  assign w_unused_inst = ^{inst_i[31:15], inst_i[7 +: REG_ADDR_WIDTH]};

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    if (w_access) begin
      if (w_size == SZ_HALF)
        w_misalign = alu_res_i[0];
      else if (w_size == SZ_WORD)
        w_misalign = (alu_res_i[1:0] != 2'b00);
    end
  end
  assign w_eff_addr = alu_res_i;
`else
  assign w_misalign = 1'b0;
  always_comb begin
    w_eff_addr = alu_res_i;
    if (w_size == SZ_HALF)
      w_eff_addr[0] = 1'b0;
    else if (w_size == SZ_WORD)
      w_eff_addr[1:0] = 2'b00;
  end
`endif

  assign w_access_ok = w_access & ~w_misalign;

  mem_align u_align (
    .i_st_size    (w_size),
    .i_st_off     (w_eff_addr[1:0]),
    .i_st_data    (rs2_data_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_ld_size    (r_ld_size),
    .i_ld_off     (r_ld_off),
    .i_ld_unsigned(r_ld_uns),
    .i_rdata      (dbus_rdata_i),
    .o_ld_data    (w_ld_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access_ok) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (dbus_gnt_i)
          w_state_nxt = r_we ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (dbus_rvalid_i)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // hold here so a stopped upstream register cannot reissue the access
        if (adv_i)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // bus fields are captured only in IDLE, so they stay stable through REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_ld_size   <= '0;
      r_ld_off    <= '0;
      r_ld_uns    <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access_ok) begin
            r_req     <= 1'b1;
            r_we      <= w_is_store;
            r_addr    <= {w_eff_addr[CPU_WIDTH-1:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_ld_size <= w_size;
            r_ld_off  <= w_eff_addr[1:0];
            r_ld_uns  <= w_f3[2];
          end
        end
        ST_REQ: begin
          if (dbus_gnt_i)
            r_req <= 1'b0;
        end
        ST_WAIT: begin
          if (dbus_rvalid_i)
            r_load_data <= w_ld_ext;
        end
        default: ;
      endcase
    end
  end

  assign dbus_req_o   = r_req;
  assign dbus_we_o    = r_we;
  assign dbus_addr_o  = r_addr;
  assign dbus_be_o    = r_be;
  assign dbus_wdata_o = r_wdata;
  assign load_data_o  = r_load_data;
  assign mem_stall_o  = w_stall & ~rst;
  assign misalign_o   = w_misalign & ~rst;
  assign reg_wr_en_o  = reg_wr_en_i & ~misalign_o;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the memory-access stage. It sits directly downstream of the execute-to-memory pipeline register and consumes that register's instruction, ALU result (effective address) and rs2 data. For loads and stores it runs a req/gnt/rvalid handshake on the data bus, and it holds the pipeline through the flow controller until the access completes. Load data is sign- or zero-extended and presented to the writeback register.

## Interface
Parameters:
- none; widths come from `CPU_WIDTH` (32) and `REG_ADDR_WIDTH` (5) in rooth_defines.v

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- inst_i  in  CPU_WIDTH  instruction from pipeline register; opcode `[6:0]`, funct3 `[14:12]`
- alu_res_i  in  CPU_WIDTH  effective address
- rs2_data_i  in  CPU_WIDTH  store data
- reg_wr_en_i  in  1  register write enable from pipeline register
- adv_i  in  1  flow controller advances the upstream register this cycle
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  CPU_WIDTH  word-aligned address (`[1:0]` = 0)
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  CPU_WIDTH  lane-replicated store data
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  read data valid
- dbus_rdata_i  in  CPU_WIDTH  read data
- mem_stall_o  out  1  request FLOW_STOP to the flow controller
- load_data_o  out  CPU_WIDTH  extended load result, registered
- reg_wr_en_o  out  1  `reg_wr_en_i & ~misalign_o`
- misalign_o  out  1  misaligned access flag (see Configuration)

## Operation
- Access detection:
  - load when opcode == `INST_TYPE_IL`
  - store when opcode == `INST_TYPE_S`
  - all other opcodes are ignored, including the refreshed bubble `inst = 0`
- Size: funct3[1:0] 00 = byte, 01 = half, 1x = word. funct3[2] = 1 selects zero-extension on loads.
- Store lanes:
  - byte: be = 1 << addr[1:0], wdata = {4{rs2[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}
  - word: be = 1111, wdata = rs2
- Loads set be by the same rule. The selected lane is extracted from rdata and extended to 32 bits.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on an aligned access, register addr/be/wdata/we, set req = 1, go to REQ.
  - REQ: hold all bus outputs stable until gnt. On gnt, drop req. A store goes to DONE; a load goes to WAIT.
  - WAIT: on rvalid, capture the extended data into load_data_o and go to DONE.
  - DONE: stay until adv_i = 1, then go to IDLE. This prevents reissue while the upstream register is stopped for other reasons.
- mem_stall_o = (IDLE & aligned access detected) | REQ | WAIT. It is combinational and forced to 0 while rst is high.
- gnt is sampled only in REQ. rvalid is ignored outside WAIT.
- load_data_o holds its value until the next load completes.
- Reset (including mid-transaction):
  - state returns to IDLE
  - dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, load_data_o and misalign_o go to 0 immediately
  - an outstanding rvalid after reset is ignored

## Timing
- Zero-wait bus (gnt in the same cycle as req, rvalid one cycle later):
  - load: C0 IDLE detect (stall = 1), C1 REQ + gnt, C2 WAIT + rvalid, C3 DONE with load_data valid and stall = 0. Three stall cycles.
  - store: C0 detect, C1 REQ + gnt, C2 DONE. Two stall cycles.
- Each gnt wait cycle adds one stall cycle; each rvalid wait cycle adds one.
- dbus_* outputs are registered and stable from the edge entering REQ until the edge after gnt.
- Back-to-back accesses: the next access is detected in the cycle after DONE + adv_i.

## Configuration
- Macro `MEM_MISALIGN_TRAP_EN` defined:
  - half with addr[0] = 1, or word with addr[1:0] != 00, starts no bus access
  - misalign_o = 1 combinationally while the instruction is present, reg_wr_en_o = 0, stall = 0
- Macro undefined:
  - misalign_o is tied to 0
  - the address is truncated to natural alignment (half clears bit 0, word clears bits 1:0) and the access proceeds

## Structure
- rooth_defines.v holds the shared constants: `INST_TYPE_IL` (0000011), `INST_TYPE_S` (0100011), the funct3 size/sign codes, and `MEM_MISALIGN_TRAP_EN`.
- The FSM state encoding is local to the block.
- One combinational sub-module, `mem_align`, generates byte enables and replicated wdata, and extracts/extends load data. The FSM and registers live in mem_lsu.

## Test plan
- SW, addr 0x1000_0008, rs2 0xDEADBEEF, gnt in the same cycle as req → one-cycle req, addr 0x1000_0008, be 1111, we = 1, stall high for 2 cycles.
- LB addr 0x2000_0003 with rdata 0x80FF_1234 → load_data_o 0xFFFF_FF80; LBU at the same address → 0x0000_0080.
- SH addr 0x2000_0002, rs2 0x0000_ABCD → be 1100, wdata 0xABCD_ABCD.
- LW with gnt delayed 3 cycles and rvalid delayed 2 cycles → addr/be stable throughout, stall high for 7 cycles, then load_data = rdata.
- LW addr 0x2000_0001:
  - with the macro → no req, misalign_o = 1, reg_wr_en_o = 0
  - without it → req issued at addr 0x2000_0000
- rst pulsed in WAIT, then rvalid arrives → req and outputs go to 0 immediately, state IDLE, load_data_o stays 0.
